octave_mode_ctrl: RTL and testbench
===================================

Name: octave_mode_ctrl

Overview:
- Consumer end of the keypad edge-detector interface. Takes the single-cycle `modekey`, `octive_up` and `octive_down` pulses and holds the synth's current effect mode and octave index.
- Adds a press-lockout window, because upstream edge detection does not debounce.
- Emits one-cycle change strobes for the voice/effect datapath.
- Sits between the keypad block and the oscillator/effect controls.

Parameters:
- NUM_OCTAVES, 8: number of octave steps. Legal range is 2..8. Octave index spans 0..NUM_OCTAVES-1.
- OCT_RESET, 4: octave index loaded at reset. Must be < NUM_OCTAVES.
- LOCKOUT_CYCLES, 100000: cycles during which further presses are ignored after an accepted press. Must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- modekey  input  1  one-cycle pulse: advance the effect mode.
- octive_up  input  1  one-cycle pulse: octave + 1.
- octive_down  input  1  one-cycle pulse: octave - 1.
- mode  output  2  current mode (mode_t): 0 NORMAL, 1 ECHO, 2 TREMOLO, 3 CHORUS.
- octave  output  3  current octave index.
- mode_changed  output  1  one-cycle strobe in the cycle `mode` takes its new value.
- octave_changed  output  1  one-cycle strobe in the cycle `octave` takes its new value.
- busy  output  1  high while in lockout.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high, sampled only on the rising edge of `clk`. This is already decided.
- Reset values: mode = NORMAL, octave = OCT_RESET, mode_changed = 0, octave_changed = 0, busy = 0, lockout counter = 0, FSM = IDLE.
- Reset asserted mid-lockout aborts the lockout. The block is back in IDLE the next cycle.
- FSM states: IDLE and LOCKOUT.
- IDLE, press selection (evaluated each cycle):
  - If modekey = 1, a mode press is accepted. Any octave pulses in the same cycle are dropped.
  - Otherwise, if exactly one of octive_up / octive_down = 1, an octave press is accepted.
  - If octive_up and octive_down are both 1, both are dropped. No press is accepted and no lockout starts.
- Accepted press, effect at the next rising edge:
  - The register updates and the matching strobe rises. Latency is 1 cycle from the input pulse to the new output value plus strobe. The strobe is high for exactly 1 cycle.
  - The FSM enters LOCKOUT and the counter loads LOCKOUT_CYCLES-1.
- Mode arithmetic: mode = mode + 1, wrapping modulo 4 (CHORUS -> NORMAL). mode_changed is always asserted.
- Octave arithmetic: saturating.
  - up at NUM_OCTAVES-1, or down at 0: octave is held and octave_changed stays 0.
  - LOCKOUT is still entered, since the press is still counted.
- LOCKOUT:
  - busy = 1 and all input pulses are ignored.
  - The counter decrements each cycle. When it is 0, the FSM goes to IDLE on the next edge.
  - busy is therefore high for exactly LOCKOUT_CYCLES cycles, starting the cycle after the accepted pulse.
  - A pulse arriving in the first IDLE cycle after lockout is accepted.
- Counter width: $clog2(LOCKOUT_CYCLES+1). The `octave` port is fixed at 3 bits; unused upper values are never reached.
- Strobes and busy are registered outputs. Nothing is combinational from the inputs.

Optional Feature:
- Macro: OCTAVE_WRAP_EN.
- Defined: octave wraps instead of saturating (up at NUM_OCTAVES-1 goes to 0; down at 0 goes to NUM_OCTAVES-1), and octave_changed is asserted on the wrap.
- Undefined: saturating behaviour as specified above.

Decomposition:
- Package keypad_pkg holds:
  - mode_t, a 2-bit enum: MODE_NORMAL, MODE_ECHO, MODE_TREMOLO, MODE_CHORUS.
  - ctrl_state_t, an enum: S_IDLE, S_LOCKOUT.
  - OCT_W = 3.
- One sub-module, lockout_timer:
  - Inputs: load, reload value.
  - Outputs: done, busy.
  - Holds the down-counter.
- The top level holds the FSM, the priority logic and the mode/octave registers.

Test Plan (LOCKOUT_CYCLES = 4, NUM_OCTAVES = 8, OCT_RESET = 4):
- Reset released, no inputs -> mode = 0, octave = 4, strobes = 0, busy = 0 for 10 cycles.
- octive_up pulse at cycle t -> octave = 5 and octave_changed = 1 at t+1 only; busy high t+1..t+4. A second up pulse at t+2 is ignored (octave stays 5). An up pulse at t+5 gives octave = 6 at t+6.
- Five modekey pulses spaced 6 cycles apart -> mode sequence 1, 2, 3, 0, 1, with mode_changed high for one cycle after each pulse.
- modekey, octive_up and octive_down all high in one cycle -> mode + 1, octave unchanged, lockout starts. Then octive_up and octive_down together, alone in IDLE -> no change, busy stays 0.
- Drive octave to 7, then octive_up -> octave stays 7, octave_changed = 0, busy still high for 4 cycles. With OCTAVE_WRAP_EN defined, the same stimulus gives octave = 0 with octave_changed = 1.
- rst asserted at the 2nd lockout cycle after a down press -> next cycle: busy = 0, octave = 4, mode = 0, and an immediate octive_down is accepted (octave = 3).

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types for the keypad consumer blocks: the effect-mode enumeration,
// the controller FSM state enumeration and the fixed octave-index width.
// No configuration macros are used in this file.
// -----------------------------------------------------------------------------
package keypad_pkg;

   // Effect modes, advanced in this order by each accepted mode press
   typedef enum logic [1:0] {
      MODE_NORMAL  = 2'd0,
      MODE_ECHO    = 2'd1,
      MODE_TREMOLO = 2'd2,
      MODE_CHORUS  = 2'd3
   } mode_t;

   // Controller states: waiting for a press, or ignoring presses
   typedef enum logic {
      S_IDLE    = 1'b0,
      S_LOCKOUT = 1'b1
   } ctrl_state_t;

   // Width of the octave index port
   localparam int OCT_W = 3;

endpackage

// File: rtl/lockout_timer.sv
// -----------------------------------------------------------------------------
// lockout_timer
// Down-counter that measures the press-lockout window. A load starts the
// window with the given reload value; the window lasts reload+1 cycles.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset, clears the window
//   load_i   : start a new window this edge
//   reload_i : count loaded on load_i (window length minus one)
//   done_o   : high in the last cycle of the window
//   busy_o   : high for every cycle of the window (registered)
// No configuration macros are used in this file.
// -----------------------------------------------------------------------------
module lockout_timer #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] reload_i,
   output logic             done_o,
   output logic             busy_o
);

   logic [WIDTH-1:0] count_q;
   logic             active_q;

   // The counter walks down from the reload value to zero; the window ends
   // on the edge after it reaches zero, so the active flag covers exactly
   // reload+1 cycles. A load always wins so a new window can start cleanly.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         active_q <= 1'b0;
      end else if (load_i) begin
         count_q  <= reload_i;
         active_q <= 1'b1;
      end else if (active_q) begin
         if (count_q == '0) begin
            active_q <= 1'b0;
         end else begin
            count_q <= count_q - WIDTH'(1);
         end
      end
   end

   assign done_o = active_q && (count_q == '0);
   assign busy_o = active_q;

endmodule

// File: rtl/octave_mode_ctrl.sv
// -----------------------------------------------------------------------------
// octave_mode_ctrl
// Consumes single-cycle keypad pulses and holds the synth's effect mode and
// octave index. After each accepted press a lockout window ignores further
// presses, since the upstream edge detector does not debounce. One-cycle
// change strobes tell the voice/effect datapath when a value moved.
// Ports:
//   clk            : system clock
//   rst            : synchronous active-high reset
//   modekey        : pulse, advance effect mode (wraps CHORUS -> NORMAL)
//   octive_up      : pulse, octave + 1
//   octive_down    : pulse, octave - 1
//   mode           : current effect mode (mode_t encoding)
//   octave         : current octave index, 0..NUM_OCTAVES-1
//   mode_changed   : one-cycle strobe when mode takes a new value
//   octave_changed : one-cycle strobe when octave takes a new value
//   busy           : high during the lockout window
// Configuration macro: OCTAVE_WRAP_EN -- when defined the octave wraps at
// both ends instead of saturating.
// -----------------------------------------------------------------------------
module octave_mode_ctrl
   import keypad_pkg::*;
#(
   parameter int NUM_OCTAVES    = 8,
   parameter int OCT_RESET      = 4,
   parameter int LOCKOUT_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             modekey,
   input  logic             octive_up,
   input  logic             octive_down,
   output logic [1:0]       mode,
   output logic [OCT_W-1:0] octave,
   output logic             mode_changed,
   output logic             octave_changed,
   output logic             busy
);

   localparam int               CNT_W   = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [OCT_W-1:0] OCT_MAX = OCT_W'(NUM_OCTAVES - 1);
   localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(LOCKOUT_CYCLES - 1);

   ctrl_state_t      state_q;
   mode_t            mode_q;
   logic [OCT_W-1:0] octave_q;
   logic [OCT_W-1:0] octave_d;
   logic             octaveMove;
   logic             modeChanged_q;
   logic             octaveChanged_q;
   logic             octavePress;
   logic             acceptPress;
   logic             timerDone;
   logic             timerBusy;

   // Pressing up and down together is treated as a bounce and dropped
   assign octavePress = octive_up ^ octive_down;
   assign acceptPress = (state_q == S_IDLE) && (modekey || octavePress);

   // Next octave value for a single up or down press. octaveMove says the
   // value actually changes; a saturated press still counts as a press and
   // starts the lockout, but produces no strobe.
   always_comb begin
      octave_d   = octave_q;
      octaveMove = 1'b0;
      if (octive_up) begin
         if (octave_q != OCT_MAX) begin
            octave_d   = octave_q + OCT_W'(1);
            octaveMove = 1'b1;
         end
`ifdef OCTAVE_WRAP_EN
         else begin
            octave_d   = '0;
            octaveMove = 1'b1;
         end
`endif
      end else if (octive_down) begin
         if (octave_q != '0) begin
            octave_d   = octave_q - OCT_W'(1);
            octaveMove = 1'b1;
         end
`ifdef OCTAVE_WRAP_EN
         else begin
            octave_d   = OCT_MAX;
            octaveMove = 1'b1;
         end
`endif
      end
   end

   // Controller FSM with registered mode/octave and strobes. In IDLE a mode
   // press outranks any octave press in the same cycle. Strobes default low
   // so each one lasts a single cycle. LOCKOUT returns to IDLE when the timer
   // reports its final cycle, so a press in the very next cycle is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         mode_q          <= MODE_NORMAL;
         octave_q        <= OCT_W'(OCT_RESET);
         modeChanged_q   <= 1'b0;
         octaveChanged_q <= 1'b0;
      end else begin
         modeChanged_q   <= 1'b0;
         octaveChanged_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (modekey) begin
                  mode_q        <= mode_t'(mode_q + 2'd1);
                  modeChanged_q <= 1'b1;
                  state_q       <= S_LOCKOUT;
               end else if (octavePress) begin
                  state_q <= S_LOCKOUT;
                  if (octaveMove) begin
                     octave_q        <= octave_d;
                     octaveChanged_q <= 1'b1;
                  end
               end
            end
            S_LOCKOUT: begin
               if (timerDone) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   lockout_timer #(
      .WIDTH (CNT_W)
   ) u_lockout_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (acceptPress),
      .reload_i (RELOAD),
      .done_o   (timerDone),
      .busy_o   (timerBusy)
   );

   assign mode           = mode_q;
   assign octave         = octave_q;
   assign mode_changed   = modeChanged_q;
   assign octave_changed = octaveChanged_q;
   assign busy           = timerBusy;

endmodule

// File: tb/tb_octave_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_octave_mode_ctrl
// Self-checking bench for octave_mode_ctrl with LOCKOUT_CYCLES = 4,
// NUM_OCTAVES = 8, OCT_RESET = 4. Honours OCTAVE_WRAP_EN for the expected
// value of the octave-boundary step.
// -----------------------------------------------------------------------------
module tb_octave_mode_ctrl;

   typedef struct {
      logic       mk;
      logic       up;
      logic       dn;
      logic       rst;
      logic [1:0] mode;
      logic [2:0] oct;
      logic       mc;
      logic       oc;
      logic       busy;
   } vec_t;

   typedef struct {
      logic [1:0] mode;
      logic [2:0] oct;
      logic       mc;
      logic       oc;
      logic       busy;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       modekey;
   logic       octiveUp;
   logic       octiveDown;
   logic [1:0] mode;
   logic [2:0] octave;
   logic       modeChanged;
   logic       octaveChanged;
   logic       busy;

   vec_t vecs[$];
   exp_t scoreboard[$];
   int   checks   = 0;
   int   failures = 0;
   int   stepNum  = 0;

   octave_mode_ctrl #(
      .NUM_OCTAVES    (8),
      .OCT_RESET      (4),
      .LOCKOUT_CYCLES (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .modekey        (modekey),
      .octive_up      (octiveUp),
      .octive_down    (octiveDown),
      .mode           (mode),
      .octave         (octave),
      .mode_changed   (modeChanged),
      .octave_changed (octaveChanged),
      .busy           (busy)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One table row: inputs for one cycle and the outputs expected after the
   // following rising edge
   function automatic void addRow(input logic mk, input logic up, input logic dn,
                                  input logic r, input logic [1:0] m, input logic [2:0] o,
                                  input logic mc, input logic oc, input logic b);
      vec_t v;
      v.mk = mk; v.up = up; v.dn = dn; v.rst = r;
      v.mode = m; v.oct = o; v.mc = mc; v.oc = oc; v.busy = b;
      vecs.push_back(v);
   endfunction

   // Idle rows after a press: busy stays up for three more cycles, then drops
   function automatic void addWait(input logic [1:0] m, input logic [2:0] o);
      for (int i = 0; i < 3; i++) addRow(1'b0, 1'b0, 1'b0, 1'b0, m, o, 1'b0, 1'b0, 1'b1);
      addRow(1'b0, 1'b0, 1'b0, 1'b0, m, o, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic compareBit(input string name, input logic [2:0] got, input logic [2:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, stepNum, got, want);
      end
   endtask

   // Pop the oldest expectation and compare it with the DUT outputs
   task automatic checkOutput();
      exp_t e;
      checks++;
      if (scoreboard.size() == 0) begin
         failures++;
         $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", stepNum);
      end else begin
         e = scoreboard.pop_front();
         compareBit("mode", {1'b0, mode}, {1'b0, e.mode});
         compareBit("octave", octave, e.oct);
         compareBit("mode_changed", {2'b0, modeChanged}, {2'b0, e.mc});
         compareBit("octave_changed", {2'b0, octaveChanged}, {2'b0, e.oc});
         compareBit("busy", {2'b0, busy}, {2'b0, e.busy});
      end
   endtask

   // Drive one cycle of inputs away from the active edge, queue the result
   // they should cause, then check just after the edge
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      @(negedge clk);
      modekey    = v.mk;
      octiveUp   = v.up;
      octiveDown = v.dn;
      rst        = v.rst;
      e.mode = v.mode; e.oct = v.oct; e.mc = v.mc; e.oc = v.oc; e.busy = v.busy;
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
      stepNum++;
      checkOutput();
   endtask

   initial begin
      logic [2:0] octAfter;
      vec_t       v;

      modekey    = 1'b0;
      octiveUp   = 1'b0;
      octiveDown = 1'b0;
      rst        = 1'b1;

      // Reset, then ten quiet cycles
      addRow(0, 0, 0, 1, 2'd0, 3'd4, 0, 0, 0);
      for (int i = 0; i < 10; i++) addRow(0, 0, 0, 0, 2'd0, 3'd4, 0, 0, 0);

      // Octave up, an ignored up inside the lockout, then an up right after
      addRow(0, 1, 0, 0, 2'd0, 3'd5, 0, 1, 1);
      addRow(0, 0, 0, 0, 2'd0, 3'd5, 0, 0, 1);
      addRow(0, 1, 0, 0, 2'd0, 3'd5, 0, 0, 1);
      addRow(0, 0, 0, 0, 2'd0, 3'd5, 0, 0, 1);
      addRow(0, 0, 0, 0, 2'd0, 3'd5, 0, 0, 0);
      addRow(0, 1, 0, 0, 2'd0, 3'd6, 0, 1, 1);
      addWait(2'd0, 3'd6);

      // Five mode presses six cycles apart: 1, 2, 3, 0, 1
      for (int k = 1; k <= 5; k++) begin
         addRow(1, 0, 0, 0, 2'(k), 3'd6, 1, 0, 1);
         addWait(2'(k), 3'd6);
         addRow(0, 0, 0, 0, 2'(k), 3'd6, 0, 0, 0);
      end

      // Mode key outranks octave keys; up+down alone is dropped
      addRow(1, 1, 1, 0, 2'd2, 3'd6, 1, 0, 1);
      addWait(2'd2, 3'd6);
      addRow(0, 1, 1, 0, 2'd2, 3'd6, 0, 0, 0);
      addRow(0, 0, 0, 0, 2'd2, 3'd6, 0, 0, 0);

      // Top octave, then an up press at the top
      addRow(0, 1, 0, 0, 2'd2, 3'd7, 0, 1, 1);
      addWait(2'd2, 3'd7);
`ifdef OCTAVE_WRAP_EN
      octAfter = 3'd0;
      addRow(0, 1, 0, 0, 2'd2, octAfter, 0, 1, 1);
`else
      octAfter = 3'd7;
      addRow(0, 1, 0, 0, 2'd2, octAfter, 0, 0, 1);
`endif
      addWait(2'd2, octAfter);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Reset in the second lockout cycle after a down press aborts the
      // lockout, and a down press immediately afterwards is accepted
      v = '{mk:0, up:0, dn:1, rst:0, mode:2'd2, oct:octAfter - 3'd1, mc:0, oc:1, busy:1};
      applyStimulus(v);
      v = '{mk:0, up:0, dn:0, rst:0, mode:2'd2, oct:octAfter - 3'd1, mc:0, oc:0, busy:1};
      applyStimulus(v);
      v = '{mk:0, up:0, dn:0, rst:1, mode:2'd0, oct:3'd4, mc:0, oc:0, busy:0};
      applyStimulus(v);
      v = '{mk:0, up:0, dn:1, rst:0, mode:2'd0, oct:3'd3, mc:0, oc:1, busy:1};
      applyStimulus(v);
      for (int i = 0; i < 3; i++) begin
         v = '{mk:0, up:0, dn:0, rst:0, mode:2'd0, oct:3'd3, mc:0, oc:0, busy:1};
         applyStimulus(v);
      end
      v = '{mk:0, up:0, dn:0, rst:0, mode:2'd0, oct:3'd3, mc:0, oc:0, busy:0};
      applyStimulus(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
